sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO: pointer/flag control, count, watermarks and error pulses around a

---
 rtl/sync_fifo_param_pkg.sv | 13 +
 rtl/fifo_sdp_ram.sv | 32 +++
 rtl/sync_fifo_param.sv | 151 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared constants for the parametrised synchronous FIFO: default geometry and read-mode encodings.
package sync_fifo_param_pkg;

    localparam int FIFO_WIDTH      = 8;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_MODE_STD   = 0;
    localparam int FIFO_MODE_FWFT  = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple-dual-port RAM: one write port, one registered read port (1-cycle latency, no reset).
module fifo_sdp_ram
    import sync_fifo_param_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata only moves on re, so it doubles as a hold register for the read side.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointers, count, flags and error pulses around fifo_sdp_ram,
// with either a 1-cycle-latency read port or a first-word-fall-through output stage.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AFULL_TH   = fifo_depth(ADDR_WIDTH) - 2,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [CW-1:0]         wptr_q, wptr_d;
    logic [CW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign wr_acc = wr_en && !full_q;

    always_comb begin
        wptr_d  = wptr_q + CW'(wr_acc);
        rptr_d  = rptr_q + CW'(ram_re);
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == DEPTH_C);
            overflow_q  <= wr_en && !wr_acc;
            underflow_q <= rd_en && !rd_acc;
        end
    end

    fifo_sdp_ram #(
        .WIDTH      (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_q[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (rptr_q[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Two-stage prefetch: RAM output register (mid) feeding the visible output register.
            logic                  out_valid_q, mid_valid_q;
            logic [DATA_WIDTH-1:0] out_data_q;
            logic                  pop, mid_take, ram_has;

            assign ram_has  = (wptr_q != rptr_q);
            assign pop      = rd_en && out_valid_q;
            assign mid_take = mid_valid_q && (!out_valid_q || pop);
            assign ram_re   = ram_has && (!mid_valid_q || mid_take);

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    mid_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    if (mid_take) begin
                        out_data_q  <= ram_rdata;
                        out_valid_q <= 1'b1;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                    end
                    if (ram_re) begin
                        mid_valid_q <= 1'b1;
                    end else if (mid_take) begin
                        mid_valid_q <= 1'b0;
                    end
                end
            end

            assign rd_acc  = pop;
            assign empty   = !out_valid_q;
            assign rd_data = out_data_q;
        end else begin : g_std
            logic empty_q;
            logic shown_q;

            // shown_q masks the unreset RAM output until a read has actually landed.
            always_ff @(posedge clk) begin
                if (rst) begin
                    empty_q <= 1'b1;
                    shown_q <= 1'b0;
                end else begin
                    empty_q <= (count_d == '0);
                    if (rd_acc) begin
                        shown_q <= 1'b1;
                    end
                end
            end

            assign rd_acc  = rd_en && !empty_q;
            assign ram_re  = rd_acc;
            assign empty   = empty_q;
            assign rd_data = shown_q ? ram_rdata : '0;
        end
    endgenerate

    assign count        = count_q;
    assign full         = full_q;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: one standard-mode and one FWFT instance (8 x 16), hand-computed expectations.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // standard-mode instance
    logic       s_rst = 1'b1, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [7:0] s_wr_data = '0, s_rd_data;
    logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic [4:0] s_count;

    // FWFT instance
    logic       f_rst = 1'b1, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_wr_data = '0, f_rd_data;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [4:0] f_count;

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_std (
        .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
        .rd_data(s_rd_data), .full(s_full), .empty(s_empty), .almost_full(s_afull),
        .almost_empty(s_aempty), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .full(f_full), .empty(f_empty), .almost_full(f_afull),
        .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        s_rst = 1'b0;
        f_rst = 1'b0;
        tick();

        // reset state
        check_val("s_rst_empty", 32'(s_empty), 32'd1);
        check_val("s_rst_full", 32'(s_full), 32'd0);
        check_val("s_rst_count", 32'(s_count), 32'd0);
        check_val("s_rst_rd_data", 32'(s_rd_data), 32'd0);
        check_val("s_rst_aempty", 32'(s_aempty), 32'd1);
        check_val("s_rst_afull", 32'(s_afull), 32'd0);
        check_val("s_rst_ovf", 32'(s_ovf), 32'd0);
        check_val("s_rst_unf", 32'(s_unf), 32'd0);
        check_val("f_rst_empty", 32'(f_empty), 32'd1);
        check_val("f_rst_rd_data", 32'(f_rd_data), 32'd0);
        check_val("f_rst_aempty", 32'(f_aempty), 32'd1);

        // mid-stream reset with 5 words held; the write in the reset cycle is dropped
        for (int i = 0; i < 5; i++) begin
            s_wr_en = 1'b1; s_wr_data = 8'h30 + 8'(i);
            tick();
        end
        s_wr_en = 1'b0;
        check_val("s_pre_rst_count", 32'(s_count), 32'd5);
        s_rst = 1'b1; s_wr_en = 1'b1;
        tick();
        s_rst = 1'b0; s_wr_en = 1'b0;
        check_val("s_midrst_count", 32'(s_count), 32'd0);
        check_val("s_midrst_empty", 32'(s_empty), 32'd1);

        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1'b1; s_wr_data = 8'(i);
            tick();
            check_val($sformatf("s_fill_count%0d", i), 32'(s_count), 32'(i + 1));
            check_val($sformatf("s_fill_afull%0d", i), 32'(s_afull), 32'(i + 1 >= 14));
            check_val($sformatf("s_fill_full%0d", i), 32'(s_full), 32'(i + 1 == 16));
        end
        s_wr_data = 8'hAA;
        tick();
        s_wr_en = 1'b0;
        check_val("s_ovf_pulse", 32'(s_ovf), 32'd1);
        check_val("s_ovf_count", 32'(s_count), 32'd16);
        tick();
        check_val("s_ovf_clear", 32'(s_ovf), 32'd0);

        // drain, one cycle read latency
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1'b1;
            tick();
            check_val($sformatf("s_drain_data%0d", i), 32'(s_rd_data), 32'(i));
            check_val($sformatf("s_drain_count%0d", i), 32'(s_count), 32'(15 - i));
        end
        check_val("s_drain_empty", 32'(s_empty), 32'd1);
        tick();
        s_rd_en = 1'b0;
        check_val("s_unf_pulse", 32'(s_unf), 32'd1);
        check_val("s_unf_hold", 32'(s_rd_data), 32'h0F);
        tick();
        check_val("s_unf_clear", 32'(s_unf), 32'd0);

        // wrap: steady simultaneous traffic at count 8
        for (int i = 0; i < 8; i++) begin
            s_wr_en = 1'b1; s_wr_data = 8'(i);
            tick();
        end
        for (int i = 0; i < 100; i++) begin
            s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 8'(i + 8);
            tick();
            check_val($sformatf("s_wrap_data%0d", i), 32'(s_rd_data), 32'(i));
            check_val($sformatf("s_wrap_count%0d", i), 32'(s_count), 32'd8);
            check_val($sformatf("s_wrap_err%0d", i), 32'({s_ovf, s_unf}), 32'd0);
        end
        s_rd_en = 1'b0;

        // refill to full, then read+write at full
        for (int i = 0; i < 8; i++) begin
            s_wr_en = 1'b1; s_wr_data = 8'hC0 + 8'(i);
            tick();
        end
        check_val("s_refill_full", 32'(s_full), 32'd1);
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 8'hEE;
        tick();
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        check_val("s_both_full_count", 32'(s_count), 32'd15);
        check_val("s_both_full_ovf", 32'(s_ovf), 32'd1);
        check_val("s_both_full_data", 32'(s_rd_data), 32'd100);
        check_val("s_both_full_flag", 32'(s_full), 32'd0);

        // read+write at empty
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 8'h77;
        tick();
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        check_val("s_both_empty_unf", 32'(s_unf), 32'd1);
        check_val("s_both_empty_count", 32'(s_count), 32'd1);
        check_val("s_both_empty_empty", 32'(s_empty), 32'd0);
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        check_val("s_both_empty_data", 32'(s_rd_data), 32'h77);

        // FWFT: single word into empty becomes visible two edges later
        f_wr_en = 1'b1; f_wr_data = 8'h5A;
        tick();
        f_wr_en = 1'b0;
        check_val("f_single_e1", 32'(f_empty), 32'd1);
        tick();
        check_val("f_single_e2", 32'(f_empty), 32'd1);
        tick();
        check_val("f_single_empty", 32'(f_empty), 32'd0);
        check_val("f_single_data", 32'(f_rd_data), 32'h5A);
        check_val("f_single_count", 32'(f_count), 32'd1);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        check_val("f_pop_empty", 32'(f_empty), 32'd1);
        check_val("f_pop_count", 32'(f_count), 32'd0);
        tick();
        check_val("f_pop_unf_none", 32'(f_unf), 32'd0);

        // FWFT burst, continuous pop
        for (int i = 0; i < 4; i++) begin
            f_wr_en = 1'b1; f_wr_data = 8'h11 + 8'(i);
            tick();
        end
        f_wr_en = 1'b0;
        tick();
        tick();
        check_val("f_burst_count", 32'(f_count), 32'd4);
        f_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("f_burst_valid%0d", i), 32'(f_empty), 32'd0);
            check_val($sformatf("f_burst_data%0d", i), 32'(f_rd_data), 32'h11 + 32'(i));
            tick();
        end
        f_rd_en = 1'b0;
        check_val("f_burst_empty", 32'(f_empty), 32'd1);
        check_val("f_burst_count0", 32'(f_count), 32'd0);

        // FWFT fill to full, then read+write at full
        for (int i = 0; i < 16; i++) begin
            f_wr_en = 1'b1; f_wr_data = 8'h80 + 8'(i);
            tick();
        end
        f_wr_en = 1'b0;
        tick();
        tick();
        check_val("f_full_flag", 32'(f_full), 32'd1);
        check_val("f_full_count", 32'(f_count), 32'd16);
        check_val("f_full_afull", 32'(f_afull), 32'd1);
        check_val("f_full_head", 32'(f_rd_data), 32'h80);
        f_wr_en = 1'b1; f_rd_en = 1'b1; f_wr_data = 8'hEE;
        tick();
        f_wr_en = 1'b0; f_rd_en = 1'b0;
        check_val("f_both_full_count", 32'(f_count), 32'd15);
        check_val("f_both_full_ovf", 32'(f_ovf), 32'd1);
        check_val("f_both_full_next", 32'(f_rd_data), 32'h81);
        check_val("f_both_full_empty", 32'(f_empty), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
